// File: rtl/cracker_pkg.sv
// Shared constants and types for the cracker array and its result path.
// Worker count is the letter workers plus the single space worker.
package cracker_pkg;

  localparam int LETTER_COUNT  = 29;
  localparam int N_WORKERS     = LETTER_COUNT + 1;
  localparam int KEY_W         = 128;
  localparam int BYTES_PER_KEY = KEY_W / 8;
  localparam int IDX_W         = 6;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SEND,
    DONE
  } state_t;

  // Search-cycle counter that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/prio_enc.sv
// Lowest-index-wins priority encoder: one-hot select, binary index and any-valid.
// The one-hot output drives the key mux directly in the collector.
module prio_enc #(
  parameter int N     = 30,
  parameter int IDX_W = 6
) (
  input  logic [N-1:0]     req,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IDX_W'(i);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_collector.sv
// Captures the first reported key (lowest worker index wins) and streams it
// MSB-first as bytes over a valid/ready interface, with winner index and search time.
module key_collector #(
  parameter int N_WORKERS = cracker_pkg::N_WORKERS,
  parameter int KEY_W     = cracker_pkg::KEY_W,
  parameter int IDX_W     = cracker_pkg::IDX_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [N_WORKERS-1:0]       completion,
  input  logic [N_WORKERS*KEY_W-1:0] keys,
  output logic                       found,
  output logic [KEY_W-1:0]           key,
  output logic [IDX_W-1:0]           winner,
  output logic [31:0]                cycles,
  output logic [7:0]                 out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       rdy
);

  import cracker_pkg::*;

  localparam int BYTES = KEY_W / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  state_t               state;
  logic [CNT_W-1:0]     byte_cnt;
  logic [KEY_W-1:0]     tx_shift;
  logic [N_WORKERS-1:0] hit_sel;
  logic [IDX_W-1:0]     hit_idx;
  logic                 hit_any;
  logic [KEY_W-1:0]     hit_key;

  prio_enc #(
    .N     (N_WORKERS),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .req    (completion),
    .onehot (hit_sel),
    .idx    (hit_idx),
    .any    (hit_any)
  );

  // AND-OR mux: at most one select bit is set, so no priority chain is needed here.
  always_comb begin
    hit_key = '0;
    for (int i = 0; i < N_WORKERS; i++) begin
      hit_key = hit_key | (keys[i*KEY_W +: KEY_W] & {KEY_W{hit_sel[i]}});
    end
  end

  // The current byte is always the top of the shift register, so it is a pure register
  // output that cannot move unless a transfer shifts it.
  assign out_data = tx_shift[KEY_W-1 -: 8];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the wide key and shift registers are reset too, since they are visible outputs that must read zero.
      state     <= IDLE;
      found     <= 1'b0;
      key       <= '0;
      winner    <= '0;
      cycles    <= '0;
      out_valid <= 1'b0;
      rdy       <= 1'b0;
      byte_cnt  <= '0;
      tx_shift  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= WAIT;
            found    <= 1'b0;
            key      <= '0;
            winner   <= '0;
            cycles   <= '0;
            rdy      <= 1'b0;
            byte_cnt <= '0;
            tx_shift <= '0;
          end
        end

        WAIT: begin
          if (start) begin
            // Restart: completion is deliberately not looked at this cycle.
            cycles <= '0;
          end else if (hit_any) begin
            found     <= 1'b1;
            key       <= hit_key;
            winner    <= hit_idx;
            tx_shift  <= hit_key;
            out_valid <= 1'b1;
            byte_cnt  <= '0;
            state     <= SEND;
          end else begin
            cycles <= sat_inc(cycles);
          end
        end

        SEND: begin
          if (out_ready) begin
            tx_shift <= {tx_shift[KEY_W-9:0], 8'h00};
            if (byte_cnt == CNT_W'(BYTES - 1)) begin
              out_valid <= 1'b0;
              rdy       <= 1'b1;
              state     <= DONE;
            end else begin
              byte_cnt <= byte_cnt + CNT_W'(1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/key_collector.md
# key_collector

Downstream stage of the parallel cracker array. It watches the per-worker completion vector and the flattened key bus, and captures the first key reported, with a deterministic lowest-index-wins priority. It then streams that 128-bit key out MSB-first as 16 bytes over a valid/ready byte interface. It also reports the winning worker index and the number of search cycles. This replaces the combinational last-wins result mux with a registered, handshaked result path toward the host/UART side.

## Interface
- N_WORKERS, 30, number of worker modules (letter workers plus the space worker); 1..64
- KEY_W, 128, key width in bits; fixed multiple of 8
- IDX_W, 6, width of winner index; must satisfy 2^IDX_W ≥ N_WORKERS

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: new search begins (same pulse that starts the workers)
- completion  in  N_WORKERS  per-worker found flag; level, held until worker reset
- keys  in  N_WORKERS*KEY_W  flattened keys; worker i at bits [i*KEY_W +: KEY_W]
- found  out  1  high from key capture until next start or reset
- key  out  KEY_W  captured key, stable while found=1
- winner  out  IDX_W  index of the captured worker
- cycles  out  32  clk cycles spent in WAIT before capture, saturating
- out_data  out  8  current key byte
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts byte
- rdy  out  1  all 16 bytes delivered; held until next start

## Operation
- FSM states: IDLE, WAIT, SEND, DONE.
- IDLE: all outputs zero. If start=1, go to WAIT and clear cycles, found, winner, key and the byte counter.
- WAIT:
  - Each cycle with no completion bit high, increment cycles, saturating at 0xFFFF_FFFF.
  - If any completion bit is high, capture the lowest set index i: key←keys[i], winner←i, found←1. Go to SEND with byte_cnt=0.
- WAIT + start=1: restart. Clear cycles and stay in WAIT; completion is not sampled that cycle.
- SEND:
  - out_valid=1 and out_data=key[KEY_W-1-8*byte_cnt -: 8], so bytes go MSB first.
  - A transfer occurs when out_valid and out_ready are both high; byte_cnt then increments.
  - The transfer of byte 15 leads to DONE.
  - out_data must not change while out_valid=1 and out_ready=0.
- DONE: rdy=1 and out_valid=0; key, winner and found are held. start=1 leads to WAIT with the same clearing as from IDLE.
- start in SEND is ignored; the transfer always completes.
- Completion changes after capture are ignored until the next WAIT.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, and found, key, winner, cycles, out_data, out_valid, rdy all zero. Reset takes effect mid-transfer with no partial byte completion.
- start in cycle t: state=WAIT at t+1. Completion is first sampled at t+1, so completion high at cycle t is ignored.
- Completion first high at cycle c in WAIT: found=1, key and winner valid, out_valid=1 at c+1. cycles equals the number of WAIT cycles before c.
- With out_ready tied high, the 16 bytes occupy cycles c+1..c+16, and rdy=1 at c+17.
- out_valid is a registered output with no combinational path from out_ready.
- When several completion bits rise in the same cycle, the lowest index wins.

## Structure
- Shared package cracker_pkg: KEY_W=128, BYTES_PER_KEY=16, the state enum (IDLE/WAIT/SEND/DONE), and N_WORKERS default = letter count + 1.
- One natural sub-module, prio_enc: an N-bit lowest-index priority encoder producing a one-hot select, IDX_W index and any-valid. The key mux is built from its one-hot output.

## Test plan
- Reset and idle: hold rst=0, then release with no start → all outputs 0 and out_valid never asserts.
- Single hit: start, then after 10 cycles assert completion[3] with keys[3]=128'h0011…EEFF, out_ready=1 → winner=3, cycles=10, bytes 00,11,…,FF on cycles c+1..c+16, rdy=1 at c+17.
- Simultaneous hits: completion[7] and completion[2] rise in the same cycle → winner=2 and key=keys[2].
- Backpressure: out_ready toggles 1,0,0,1,… → no byte lost or duplicated, out_data stable while stalled, exactly 16 transfers.
- Restart and stale completion: completion[5] already high at start → ignored that cycle, captured on the next cycle with cycles=0. start during SEND → ignored and transfer completes.
- Mid-transfer reset: assert rst=0 after byte 6 → outputs immediately 0. A new start and hit then sends all 16 bytes from byte 0.
